fn_sw_nch: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered selector; next generation of the 2:1 fn_sw switch.
//  Two modes: fixed channel select (sel), or round-robin across valid channels.

---
 rtl/fn_sw_pkg.sv | 47 ++++
 rtl/fn_sw_rr_arb.sv | 34 +++
 rtl/fn_sw_nch.sv | 105 ++++++++++
 tb/tb_fn_sw_nch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fn_sw_pkg.sv
// Package: fn_sw_pkg
// Shared definitions for the fn_sw_nch channel selector family.
//   MODE_FIXED / MODE_RR : values of the mode input
//   sw_width()           : width of a channel index for a given channel count
//   rot_pri_enc()        : rotating priority encoder used by the round-robin arbiter
package fn_sw_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bounds of the supported configuration, used to size the helper
  // function arguments so one function serves every channel count.
  localparam int MAX_CH = 16;
  localparam int MAX_SW = 4;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } rr_pick_t;

  // Channel index width; a 2-channel switch still needs a 1-bit index.
  function automatic int sw_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  // Finds the first set bit of vec scanning ptr+1, ptr+2, ... modulo n_ch.
  // ptr is assumed to be < n_ch, so one conditional subtract replaces modulo.
  function automatic rr_pick_t rot_pri_enc(input logic [MAX_CH-1:0] vec,
                                           input logic [MAX_SW-1:0] ptr,
                                           input int                n_ch);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= n_ch) begin
        cand = int'(ptr) + k;
        if (cand >= n_ch) cand = cand - n_ch;
        if (!pick.found && vec[cand]) begin
          pick.found = 1'b1;
          pick.idx   = MAX_SW'(cand);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fn_sw_rr_arb.sv
// Module: fn_sw_rr_arb
// Combinational rotating-priority arbiter. The channel after ptr has the
// highest priority, wrapping around the channel count.
//   req     in  N_CH  request vector
//   ptr     in  SW    last granted channel
//   gnt     out N_CH  one-hot grant (zero when no request)
//   gnt_idx out SW    index of the granted channel
//   found   out 1     any request granted
module fn_sw_rr_arb
  import fn_sw_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int SW   = sw_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [SW-1:0]   gnt_idx,
  output logic            found
);

  rr_pick_t pick;

  always_comb begin
    pick    = rot_pri_enc(MAX_CH'(req), MAX_SW'(ptr), N_CH);
    found   = pick.found;
    gnt_idx = SW'(pick.idx);
    gnt     = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt[i] = pick.found && (pick.idx == MAX_SW'(i));
    end
  end

endmodule

// File: rtl/fn_sw_nch.sv
// Module: fn_sw_nch
// N-channel registered selector with valid/ready handshakes. Picks one input
// channel either by a fixed select or round-robin over the valid channels and
// presents it through a single output register.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_vld    producer data (channel i at [i*WIDTH +: WIDTH]) and valids
//   in_rdy            per-channel ready, one-hot or zero
//   mode, sel         MODE_FIXED uses sel, MODE_RR rotates over valid channels
//   out_data/out_ch   registered word and the channel that produced it
//   out_vld/out_rdy   output handshake
module fn_sw_nch
  import fn_sw_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SW    = sw_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_vld,
  output logic [N_CH-1:0]       in_rdy,
  input  logic                  mode,
  input  logic [SW-1:0]         sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_ch,
  output logic                  out_vld,
  input  logic                  out_rdy
);

  logic             ld_en;
  logic [SW-1:0]    rr_ptr;
  logic [N_CH-1:0]  rr_gnt;
  logic [SW-1:0]    rr_idx;
  logic             rr_found;
  logic [N_CH-1:0]  fix_gnt;
  logic             fix_found;
  logic [N_CH-1:0]  grant;
  logic [SW-1:0]    grant_idx;
  logic             any_grant;
  logic [WIDTH-1:0] grant_data;

  fn_sw_rr_arb #(.N_CH(N_CH)) u_arb (
    .req     (in_vld),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .found   (rr_found)
  );

  // Fixed select only matches existing channels, so sel >= N_CH simply
  // yields no grant.
  always_comb begin
    fix_gnt   = '0;
    fix_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if ((sel == SW'(i)) && in_vld[i]) begin
        fix_gnt[i] = 1'b1;
        fix_found  = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      grant     = rr_gnt;
      grant_idx = rr_idx;
      any_grant = rr_found;
    end else begin
      grant     = fix_gnt;
      grant_idx = sel;
      any_grant = fix_found;
    end
  end

  // The register can accept a word when empty or when its word leaves now.
  assign ld_en  = !out_vld || out_rdy;
  assign in_rdy = grant & {N_CH{ld_en}};

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Data and channel hold when nothing is granted so the bus only moves on
  // real words; the round-robin pointer advances only on an RR transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      rr_ptr   <= SW'(N_CH - 1);
    end else if (ld_en) begin
      out_vld <= any_grant;
      if (any_grant) begin
        out_data <= grant_data;
        out_ch   <= grant_idx;
        if (mode == MODE_RR) rr_ptr <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_fn_sw_nch.sv
// Testbench: tb_fn_sw_nch
// Drives a 4-channel instance through directed and random traffic with a
// scoreboard of accepted words, plus a 3-channel instance for the
// out-of-range select and a 2-channel 1-bit instance for the legacy sweep.
module tb_fn_sw_nch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel, 8-bit instance
  logic [31:0] in_data = '0;
  logic [3:0]  in_vld = '0;
  logic [3:0]  in_rdy;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_vld;
  logic        out_rdy = 1'b0;

  // 3-channel, 8-bit instance
  logic [23:0] in_data3 = 24'h332211;
  logic [2:0]  in_vld3 = '0;
  logic [2:0]  in_rdy3;
  logic [1:0]  sel3 = '0;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_vld3;

  // 2-channel, 1-bit instance
  logic [1:0]  in_data2 = '0;
  logic [1:0]  in_rdy2;
  logic        sel2 = 1'b0;
  logic [0:0]  out_data2;
  logic [0:0]  out_ch2;
  logic        out_vld2;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } sb_t;
  sb_t sb[$];
  int  mptr = 3;

  fn_sw_nch #(.N_CH(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld),
    .in_rdy(in_rdy), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_vld(out_vld), .out_rdy(out_rdy)
  );

  fn_sw_nch #(.N_CH(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_vld(in_vld3),
    .in_rdy(in_rdy3), .mode(1'b0), .sel(sel3), .out_data(out_data3),
    .out_ch(out_ch3), .out_vld(out_vld3), .out_rdy(1'b1)
  );

  fn_sw_nch #(.N_CH(2), .WIDTH(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_vld(2'b11),
    .in_rdy(in_rdy2), .mode(1'b0), .sel(sel2), .out_data(out_data2),
    .out_ch(out_ch2), .out_vld(out_vld2), .out_rdy(1'b1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference grant decision for the 4-channel instance.
  function automatic int model_grant(input logic m, input logic [1:0] s,
                                     input logic [3:0] v, input int ptr);
    int idx;
    idx = -1;
    if (m == 1'b0) begin
      if (v[s]) idx = int'(s);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (idx < 0 && v[(ptr + k) % 4]) idx = (ptr + k) % 4;
      end
    end
    return idx;
  endfunction

  // Mid-cycle monitor: inputs and outputs are stable here, and the decision
  // seen now is the one the next rising edge commits.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        sb.delete();
        mptr = 3;
      end else begin
        automatic bit occ = (sb.size() != 0);
        automatic bit ld  = !occ || out_rdy;
        automatic int g   = model_grant(mode, sel, in_vld, mptr);
        automatic logic [3:0] exp_rdy = '0;
        checkOutput("sb_out_vld", 32'(out_vld), 32'(occ));
        if (occ && out_rdy) begin
          automatic sb_t e = sb.pop_front();
          checkOutput("sb_data", 32'(out_data), 32'(e.data));
          checkOutput("sb_ch", 32'(out_ch), 32'(e.ch));
        end
        if (g >= 0 && ld) exp_rdy[g] = 1'b1;
        checkOutput("in_rdy", 32'(in_rdy), 32'(exp_rdy));
        checkOutput("rdy_onehot", 32'($countones(in_rdy) <= 1), 1);
        if (g >= 0 && ld) begin
          sb.push_back('{data: in_data[g*8 +: 8], ch: 2'(g)});
          if (mode) mptr = g;
        end
      end
    end
  end

  initial begin
    mon_en = 1'b1;
    tick();
    checkOutput("rst_vld", 32'(out_vld), 0);
    checkOutput("rst_data", 32'(out_data), 0);
    checkOutput("rst_ch", 32'(out_ch), 0);
    tick();
    rst_n = 1'b1;

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_vld = 4'b1111; out_rdy = 1'b1;
    in_data = 32'h44_A5_22_11;
    #1 checkOutput("fix_in_rdy", 32'(in_rdy), 32'h4);
    tick();
    checkOutput("fix_data", 32'(out_data), 32'hA5);
    checkOutput("fix_ch", 32'(out_ch), 2);
    checkOutput("fix_vld", 32'(out_vld), 1);

    // Backpressure holds the word
    out_rdy = 1'b0;
    in_data = 32'h44_3C_22_11;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("bp_in_rdy", 32'(in_rdy), 0);
      tick();
      checkOutput("bp_data", 32'(out_data), 32'hA5);
    end
    out_rdy = 1'b1;
    #1 checkOutput("bp_rel_rdy", 32'(in_rdy), 32'h4);
    tick();
    checkOutput("bp_rel_data", 32'(out_data), 32'h3C);

    // Asynchronous reset between edges while a word is held
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_vld", 32'(out_vld), 0);
    checkOutput("arst_data", 32'(out_data), 0);
    checkOutput("arst_ch", 32'(out_ch), 0);
    tick();
    tick();

    // Round-robin over all channels from reset
    mode = 1'b1; in_vld = 4'b1111; out_rdy = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rr_full_ch", 32'(out_ch), 32'(k % 4));
    end

    // Round-robin over a sparse set, then no requests
    rst_n = 1'b0;
    tick();
    in_vld = 4'b1010;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rr_sparse_ch", 32'(out_ch), (k % 2 == 0) ? 1 : 3);
    end
    in_vld = 4'b0000;
    tick();
    checkOutput("rr_idle_vld", 32'(out_vld), 0);

    // Fixed select of a channel that is not valid
    mode = 1'b0; sel = 2'd3; in_vld = 4'b0111;
    #1 checkOutput("fix_inv_rdy", 32'(in_rdy), 0);
    tick();
    checkOutput("fix_inv_vld", 32'(out_vld), 0);

    // Out-of-range select on the 3-channel instance
    sel3 = 2'd3; in_vld3 = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput("oor_rdy", 32'(in_rdy3), 0);
      tick();
      checkOutput("oor_vld", 32'(out_vld3), 0);
    end
    sel3 = 2'd2;
    tick();
    checkOutput("n3_sel2_vld", 32'(out_vld3), 1);
    checkOutput("n3_sel2_data", 32'(out_data3), 32'h33);

    // Legacy 2:1 sweep
    for (int c = 0; c < 8; c++) begin
      automatic logic [2:0] cv = 3'(c);
      in_data2 = cv[1:0];
      sel2 = cv[2];
      tick();
      checkOutput("legacy_data", 32'(out_data2), 32'(cv[2] ? cv[1] : cv[0]));
    end

    // Random traffic under random backpressure
    for (int k = 0; k < 400; k++) begin
      mode    = 1'($urandom_range(0, 1));
      sel     = 2'($urandom_range(0, 3));
      in_vld  = 4'($urandom_range(0, 15));
      in_data = $urandom;
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain and confirm every accepted word came out
    in_vld = 4'b0000; out_rdy = 1'b1;
    repeat (3) tick();
    checkOutput("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
